// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: digit-select encodings and display constants shared by the seg7_scan block
package seg7_scan_pkg;
  typedef enum logic [1:0] {D4 = 2'b00, D3 = 2'b01, D2 = 2'b10, D1 = 2'b11} digit_t;
  localparam int BCD_MAX = 9;
  localparam int VALUE_MAX = 9999;
  localparam int CONV_STEPS = 14;
endpackage

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: sequential double-dabble converter, one input bit per cycle, MSB first
module seg7_bin2bcd
  import seg7_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_next
);
  logic [13:0] sh;
  logic [15:0] acc, adj;
  logic [3:0]  cnt;
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = acc[i*4 +: 4] > 4'd4 ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    bcd_next = {adj[14:0], sh[13]};
    done = busy && cnt == 4'(CONV_STEPS - 1);
  end
  // done is high during the cycle whose closing edge performs the final shift
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      acc  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      sh   <= value;
      acc  <= '0;
    end else if (busy) begin
      sh   <= sh << 1;
      acc  <= bcd_next;
      cnt  <= cnt + 4'd1;
      busy <= !done;
    end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: binary-to-BCD display scanner driving an external seg7 decoder.
// Define SEG7_SCAN_SATURATE_EN to display out-of-range loads as 9999 instead of dropping them.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 12500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  bits,
  output logic [1:0]  digit
);
  logic [15:0] presc, disp, bcd_next;
  logic [13:0] conv_in;
  logic        accept, over, start, done, wrap;
  digit_t      sel;
  always_comb begin
    accept = load && !busy;
    over = value_in > 14'(VALUE_MAX);
`ifdef SEG7_SCAN_SATURATE_EN
    start = accept;
    conv_in = over ? 14'(VALUE_MAX) : value_in;
`else
    start = accept && !over;
    conv_in = value_in;
`endif
    wrap = presc == 16'(REFRESH_DIV - 1);
    bits = disp[{sel, 2'b00} +: 4];
    digit = sel;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      presc <= '0;
      sel   <= D4;
      disp  <= '0;
      ovf   <= 1'b0;
    end else begin
      presc <= wrap ? 16'd0 : presc + 16'd1;
      sel   <= wrap ? digit_t'(sel + 2'd1) : sel;
      disp  <= done ? bcd_next : disp;
      ovf   <= accept ? over : ovf;
    end
  seg7_bin2bcd u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (conv_in),
    .busy     (busy),
    .done     (done),
    .bcd_next (bcd_next)
  );
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with a decimal reference model (REFRESH_DIV=4)
module tb_seg7_scan;
`ifdef SEG7_SCAN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    int val;
    int due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value_in = '0;
  logic        load = 1'b0;
  logic        busy, ovf;
  logic [3:0]  bits;
  logic [1:0]  digit;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rel = 0;
  int   shown = 0;
  bit   exp_ovf = 1'b0;
  bit   armed = 1'b0;
  logic prev_busy = 1'b0;
  int   p10[4] = '{1, 10, 100, 1000};

  seg7_scan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .ovf      (ovf),
    .bits     (bits),
    .digit    (digit)
  );

  always #5 clk = ~clk;

  // cycle counters: absolute, and edges since the last reset edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rel <= rst_n ? rel + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // drive one clock edge of inputs, then update the expected-result queue
  task automatic step(input bit rst, input bit ld, input int val);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rst;
    load = ld;
    value_in = 14'(val);
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      exp_ovf = 1'b0;
    end else if (ld && q.size() == 0) begin
      exp_ovf = val > 9999;
      if (val <= 9999 || SAT) begin
        e.val = val > 9999 ? 9999 : val;
        e.due = cyc + 14;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  // monitor: commits are taken when the DUT drops busy; every cycle is checked
  initial begin
    exp_t e;
    int d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b1;
        shown = 0;
      end else if (armed && prev_busy === 1'b1 && busy === 1'b0) begin
        chk("commit_pending", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", cyc, e.due);
          shown = e.val;
        end
      end
      if (armed) begin
        d = (rel / 4) % 4;
        chk("digit", 32'(digit), d);
        chk("bits", 32'(bits), (shown / p10[d]) % 10);
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
      end
      prev_busy = busy;
    end
  end

  initial begin
    int v;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    idle(20);
    step(1'b1, 1'b1, 4721);
    idle(20);
    step(1'b1, 1'b1, 1234);
    idle(4);
    step(1'b1, 1'b1, 9876);
    idle(20);
    step(1'b1, 1'b1, 0);
    idle(18);
    step(1'b1, 1'b1, 9999);
    idle(18);
    step(1'b1, 1'b1, 12000);
    idle(20);
    step(1'b1, 1'b1, 5555);
    idle(6);
    step(1'b0, 1'b0, 0);
    idle(8);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      step($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), v);
    end
    idle(20);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 12500, clock cycles each digit is held before the scan advances (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port value_in  input  14  unsigned binary value to display, legal 0..9999.
REQ-005 SHALL have port load  input  1  request to convert and display value_in; sampled on a clk edge.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port ovf  output  1  high when the most recently accepted value_in exceeded 9999.
REQ-008 SHALL have port bits  output  4  BCD digit for the currently selected position, driven to the seg7 decoder.
REQ-009 SHALL have port digit  output  2  position select for the seg7 decoder: 00=D4 ones, 01=D3 tens, 10=D2 hundreds, 11=D1 thousands.

Function
REQ-010 SHALL accept load only when busy=0; a load with busy=1 SHALL be ignored with no side effect.
REQ-011 SHALL capture value_in on the accepting edge (E0) and set busy=1 from E0.
REQ-012 SHALL convert with sequential shift-add-3 (double dabble): one input bit per cycle, MSB first, 14 shift edges E1..E14.
REQ-013 SHALL write all four BCD digits into the display register together at E14 and clear busy at E14; total latency 14 cycles after accept.
REQ-014 SHALL never update the display register partially; bits SHALL show the previous value until E14.
REQ-015 SHALL keep a prescaler counting 0..REFRESH_DIV-1 continuously, independent of conversion activity.
REQ-016 SHALL advance digit by one (00->01->10->11->00) on the edge where the prescaler is at REFRESH_DIV-1, then reload the prescaler to 0.
REQ-017 SHALL drive bits combinationally from the display register entry selected by the registered digit, so bits and digit always change together.
REQ-018 SHALL, when a commit (E14) and a scan advance fall on the same edge, show the new digit position with the new value on the next cycle.
REQ-019 SHALL always drive bits in 0..9; codes 10..15 SHALL never appear.
REQ-020 SHALL set ovf at E0 when value_in > 9999 and clear it at E0 when value_in <= 9999.

Reset
REQ-021 SHALL, at a clk edge with rst_n=0, clear the prescaler, digit=00, display register to 0000 (bits=0), busy=0, ovf=0, and the conversion shift register.
REQ-022 SHALL abort any conversion in progress on reset; no partial result is committed.
REQ-023 SHALL ignore load on any edge where rst_n=0.

Configuration
REQ-024 SHALL use macro SEG7_SCAN_SATURATE_EN.
REQ-025 SHALL, with SEG7_SCAN_SATURATE_EN defined, convert an out-of-range value_in as 9999 (normal 14-cycle conversion, ovf=1).
REQ-026 SHALL, without SEG7_SCAN_SATURATE_EN, drop an out-of-range load: busy stays 0, display unchanged, ovf=1.

Structure
REQ-027 SHALL place in the shared display package: the digit-select encodings (D4..D1), BCD_MAX=9, VALUE_MAX=9999, and CONV_STEPS=14.
REQ-028 SHALL split into top seg7_scan (prescaler, digit counter, display register, output mux) and one sub-module seg7_bin2bcd (sequential converter with start/busy/done).
REQ-029 SHALL instantiate the existing seg7 decoder outside this block; seg7_scan SHALL not drive HEX.

Verification (REFRESH_DIV=4 unless stated)
REQ-030 SHALL cover reset: rst_n low 3 cycles then high -> digit=00, bits=0, busy=0, ovf=0; digit steps 00,01,10,11,00 every 4 cycles.
REQ-031 SHALL cover conversion: load with value_in=4721 -> busy high 14 cycles; after E14, digit 00/01/10/11 show bits 1/2/7/4.
REQ-032 SHALL cover busy rejection: load 1234, then load 9876 at E5 -> display 1234 after E14; the second load has no effect.
REQ-033 SHALL cover bounds: load 0 -> 0,0,0,0; load 9999 -> 9,9,9,9; ovf=0 in both cases.
REQ-034 SHALL cover overflow: load 12000 -> ovf=1 and display 9999 with SEG7_SCAN_SATURATE_EN; without it, ovf=1, busy never rises and the previous display is kept.
REQ-035 SHALL cover reset mid-conversion: rst_n low at E7 of loading 5555 -> display 0000, busy=0, digit=00 the next cycle.
